gpio_pad_debounce: RTL and testbench
====================================

GPIO_PAD_DEBOUNCE -- requirements
Module: gpio_pad_debounce

Interface
REQ-001 SHALL have parameter GpioCount, default 32: number of GPIO pins conditioned.
REQ-002 SHALL have parameter CntWidth, default 8: width of the debounce counter and limit.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state is rising-edge clocked.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port pad_gpio_i, input, GpioCount bits: raw pad p2c values, asynchronous to clk_i.
REQ-006 SHALL have port debounce_en_i, input, GpioCount bits: per-pin enable; 1 = filter, 0 = bypass.
REQ-007 SHALL have port debounce_limit_i, input, CntWidth bits: stability threshold L, shared by all pins.
REQ-008 SHALL have port event_clr_i, input, GpioCount bits: per-pin clear of the sticky event bits.
REQ-009 SHALL have port gpio_o, output, GpioCount bits: conditioned level driven to the SoC gpio_i.
REQ-010 SHALL have port rise_o, output, GpioCount bits: single-cycle rising-edge pulse of gpio_o.
REQ-011 SHALL have port fall_o, output, GpioCount bits: single-cycle falling-edge pulse of gpio_o.
REQ-012 SHALL have port event_o, output, GpioCount bits: sticky record of any edge per pin.
REQ-013 SHALL have port irq_o, output, 1 bit: OR-reduction of event_o.

Function
REQ-014 SHALL pass each pad_gpio_i bit through a 2-flop synchronizer; sync[i] is the second flop's output.
REQ-015 SHALL hold, per pin, a registered level gpio_q (driving gpio_o), a previous level gpio_d, and a counter cnt[CntWidth-1:0].
REQ-016 Bypass (debounce_en_i[i]=0): gpio_q[i] <= sync[i] every cycle and cnt[i] <= 0; pad-to-gpio_o latency is 3 cycles.
REQ-017 Filter, sync[i]==gpio_q[i]: cnt[i] <= 0 and gpio_q[i] is held.
REQ-018 Filter, sync[i]!=gpio_q[i] and cnt[i] >= L: gpio_q[i] <= sync[i] and cnt[i] <= 0.
REQ-019 Filter, sync[i]!=gpio_q[i] and cnt[i] < L: cnt[i] <= cnt[i]+1.
REQ-020 Consequence of REQ-017 to REQ-019: gpio_o changes after L+1 consecutive differing sync cycles; L=0 behaves like bypass; a glitch of L or fewer cycles is discarded.
REQ-021 The counter SHALL never wrap, since it only increments while cnt < L <= 2^CntWidth-1.
REQ-022 SHALL compare cnt against the current debounce_limit_i; lowering L mid-count so that cnt >= L SHALL update gpio_q on that cycle.
REQ-023 Toggling debounce_en_i mid-count SHALL take effect in the same cycle, following REQ-016 or REQ-017 to REQ-019.
REQ-024 gpio_d[i] <= gpio_q[i] every cycle; rise_o = gpio_q & ~gpio_d and fall_o = ~gpio_q & gpio_d (combinational from flops), so each edge asserts its pulse for exactly the first cycle of the new gpio_o level.
REQ-025 event_q[i] SHALL set on rise_o[i] | fall_o[i], clear on event_clr_i[i], and set SHALL win when both occur in the same cycle.
REQ-026 SHALL drive event_o = event_q and irq_o = |event_q, with no additional latency.
REQ-027 Pins SHALL be fully independent; simultaneous activity on any set of pins SHALL NOT interact.

Reset
REQ-028 With rst_i high at a clock edge, all synchronizer flops, gpio_q, gpio_d, cnt and event_q SHALL become 0; gpio_o, rise_o, fall_o, event_o and irq_o are then 0.
REQ-029 Reset asserted mid-count SHALL discard the count, and no edge pulse SHALL result from the reset itself.
REQ-030 After release with a pad held high, the pin SHALL behave as a normal rising transition from 0.

Verification
REQ-031 Bypass: en=0, pad[0] 0->1 at cycle T -> gpio_o[0]=1 at T+3, rise_o[0] high only at T+3, event_o[0] and irq_o high from T+3.
REQ-032 Filter: en=1, L=4, pad[5] 0->1 held -> gpio_o[5] rises 5 cycles after sync[5] rises; a 4-cycle pulse on pad[5] -> gpio_o[5] stays 0 and event_o[5] stays 0.
REQ-033 Clear race: event_q[3]=1, event_clr_i[3]=1 in the same cycle as a new fall_o[3] -> event_o[3] stays 1; clear alone next cycle -> 0, irq_o 0 if no other bits are set.
REQ-034 Limit change: L=200 with cnt[1]=10, L changed to 5 -> gpio_o[1] updates on the next edge.
REQ-035 Reset: rst_i pulsed while cnt[2]=3 and event_q=0xFFFF_FFFF -> all outputs 0 next cycle; pad held high with L=0 -> gpio_o[2] high 3 cycles after release, with one rise pulse.
REQ-036 Independence: all 32 pads toggled together with mixed en and L=2 -> each pin meets REQ-016 or REQ-020, and event_o=0xFFFF_FFFF.

Source files
------------

// File: rtl/gpio_pad_debounce.sv
// GPIO pad input conditioning: 2-flop synchronizer, per-pin stability
// filter with a shared limit, edge pulses, sticky edge events and an IRQ.
module gpio_pad_debounce #(
  parameter int GpioCount = 32,
  parameter int CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [GpioCount-1:0] pad_gpio_i,
  input  logic [GpioCount-1:0] debounce_en_i,
  input  logic [CntWidth-1:0]  debounce_limit_i,
  input  logic [GpioCount-1:0] event_clr_i,
  output logic [GpioCount-1:0] gpio_o,
  output logic [GpioCount-1:0] rise_o,
  output logic [GpioCount-1:0] fall_o,
  output logic [GpioCount-1:0] event_o,
  output logic                 irq_o
);

  logic [GpioCount-1:0] sync_meta;
  logic [GpioCount-1:0] sync;
  logic [GpioCount-1:0] gpio_q;
  logic [GpioCount-1:0] gpio_d;
  logic [GpioCount-1:0] gpio_n;
  logic [CntWidth-1:0]  cnt   [GpioCount];
  logic [CntWidth-1:0]  cnt_n [GpioCount];
  logic [GpioCount-1:0] event_q;
  logic [GpioCount-1:0] event_n;

  // Two-flop synchronizer for the asynchronous pad inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= pad_gpio_i;
      sync      <= sync_meta;
    end
  end

  // Per-pin filter decision; the limit is the live input, so lowering it
  // mid-count releases the pending level on the very next edge.
  always_comb begin
    for (int i = 0; i < GpioCount; i++) begin
      gpio_n[i] = gpio_q[i];
      cnt_n[i]  = '0;
      if (!debounce_en_i[i]) begin
        gpio_n[i] = sync[i];
      end else if (sync[i] != gpio_q[i]) begin
        if (cnt[i] >= debounce_limit_i) begin
          gpio_n[i] = sync[i];
        end else begin
          cnt_n[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Edge pulses cover the first cycle of each new level.
  always_comb begin
    rise_o = gpio_q & ~gpio_d;
    fall_o = ~gpio_q & gpio_d;
  end

  // Sticky events: the pending level change sets the bit on the same edge as
  // gpio_q so event_o tracks the pulse with no lag; the visible pulse term
  // keeps set winning over a clear issued during the pulse cycle.
  always_comb begin
    event_n = (event_q & ~event_clr_i) | rise_o | fall_o | (gpio_n ^ gpio_q);
  end

  // Filter, edge-history and event state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpio_q  <= '0;
      gpio_d  <= '0;
      event_q <= '0;
      for (int i = 0; i < GpioCount; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      gpio_q  <= gpio_n;
      gpio_d  <= gpio_q;
      event_q <= event_n;
      for (int i = 0; i < GpioCount; i++) begin
        cnt[i] <= cnt_n[i];
      end
    end
  end

  assign gpio_o  = gpio_q;
  assign event_o = event_q;
  assign irq_o   = |event_q;

endmodule

// File: tb/tb_gpio_pad_debounce.sv
// Scenario bench for gpio_pad_debounce: expected output snapshots are queued
// with their due cycle when stimulus is applied and checked when they fall due.
module tb_gpio_pad_debounce;
  localparam int N = 32;
  localparam int W = 8;
  localparam logic [N-1:0] ALL = '1;
  localparam logic [N-1:0] EN_MIX = 32'hA5A5_5A5A;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] pad_gpio_i;
  logic [N-1:0] debounce_en_i;
  logic [W-1:0] debounce_limit_i;
  logic [N-1:0] event_clr_i;
  logic [N-1:0] gpio_o;
  logic [N-1:0] rise_o;
  logic [N-1:0] fall_o;
  logic [N-1:0] event_o;
  logic         irq_o;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] mask;
    logic [N-1:0] gpio;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] evt;
    logic         irq;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  gpio_pad_debounce #(.GpioCount(N), .CntWidth(W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pad_gpio_i       (pad_gpio_i),
    .debounce_en_i    (debounce_en_i),
    .debounce_limit_i (debounce_limit_i),
    .event_clr_i      (event_clr_i),
    .gpio_o           (gpio_o),
    .rise_o           (rise_o),
    .fall_o           (fall_o),
    .event_o          (event_o),
    .irq_o            (irq_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void exp_at(input int c, input logic [N-1:0] m, input logic [N-1:0] g,
                                 input logic [N-1:0] r, input logic [N-1:0] f,
                                 input logic [N-1:0] ev, input logic irq, input string nm);
    exp_t x;
    x.cyc = c; x.mask = m; x.gpio = g; x.rise = r; x.fall = f; x.evt = ev; x.irq = irq;
    x.name = nm;
    sb.push_back(x);
  endfunction

  task automatic apply_reset();
    pad_gpio_i = '0; debounce_en_i = '0; debounce_limit_i = '0; event_clr_i = '0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; pad_gpio_i = ALL; debounce_en_i = '0; debounce_limit_i = '0;
    event_clr_i = ALL;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({gpio_o, rise_o, fall_o, event_o, irq_o} !== '0) begin
      bad++;
      $display("FAIL reset_state got gpio=%h rise=%h fall=%h evt=%h irq=%b want all 0",
               gpio_o, rise_o, fall_o, event_o, irq_o);
    end
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if ({gpio_o, rise_o, fall_o, event_o, irq_o} !== '0) begin
      bad++;
      $display("FAIL reset_hold got gpio=%h rise=%h fall=%h evt=%h irq=%b want all 0",
               gpio_o, rise_o, fall_o, event_o, irq_o);
    end
    rst_i = 1'b0; pad_gpio_i = '0; event_clr_i = '0;
  endtask

  task automatic test_bypass();
    int t;
    apply_reset();
    t = cyc;
    pad_gpio_i[0] = 1'b1;
    exp_at(t+2, 32'h1, 0,     0,     0,     0,     1'b0, "byp_pre");
    exp_at(t+3, 32'h1, 32'h1, 32'h1, 0,     32'h1, 1'b1, "byp_rise");
    exp_at(t+4, 32'h1, 32'h1, 0,     0,     32'h1, 1'b1, "byp_hold");
    exp_at(t+7, 32'h1, 0,     0,     32'h1, 32'h1, 1'b1, "byp_fall");
    exp_at(t+8, 32'h1, 0,     0,     0,     32'h1, 1'b1, "byp_fall_end");
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_i); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if ({gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask, event_o & e.mask, irq_o} !==
            {e.gpio & e.mask, e.rise & e.mask, e.fall & e.mask, e.evt & e.mask, e.irq}) begin
          bad++;
          $display("FAIL %s cyc=%0d got g=%h r=%h f=%h e=%h irq=%b want g=%h r=%h f=%h e=%h irq=%b",
                   e.name, cyc, gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask,
                   event_o & e.mask, irq_o, e.gpio, e.rise, e.fall, e.evt, e.irq);
        end
      end
      if (k == 4) pad_gpio_i[0] = 1'b0;
    end
  endtask

  task automatic test_filter();
    int t;
    apply_reset();
    t = cyc;
    debounce_en_i = 32'h20; debounce_limit_i = 8'd4; pad_gpio_i[5] = 1'b1;
    exp_at(t+2, 32'h20, 0,      0,      0, 0,      1'b0, "flt_sync");
    exp_at(t+6, 32'h20, 0,      0,      0, 0,      1'b0, "flt_wait");
    exp_at(t+7, 32'h20, 32'h20, 32'h20, 0, 32'h20, 1'b1, "flt_rise");
    exp_at(t+8, 32'h20, 32'h20, 0,      0, 32'h20, 1'b1, "flt_hold");
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_i); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if ({gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask, event_o & e.mask, irq_o} !==
            {e.gpio & e.mask, e.rise & e.mask, e.fall & e.mask, e.evt & e.mask, e.irq}) begin
          bad++;
          $display("FAIL %s cyc=%0d got g=%h r=%h f=%h e=%h irq=%b want g=%h r=%h f=%h e=%h irq=%b",
                   e.name, cyc, gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask,
                   event_o & e.mask, irq_o, e.gpio, e.rise, e.fall, e.evt, e.irq);
        end
      end
    end
  endtask

  // Pin 5 gets an L-cycle pulse (discarded), pin 6 an L+1-cycle pulse (passes).
  task automatic test_glitch();
    int t;
    apply_reset();
    t = cyc;
    debounce_en_i = ALL; debounce_limit_i = 8'd4; pad_gpio_i = 32'h60;
    exp_at(t+6,  32'h60, 0,      0,      0,      0,      1'b0, "glt_count");
    exp_at(t+7,  32'h60, 32'h40, 32'h40, 0,      32'h40, 1'b1, "glt_rise6");
    exp_at(t+8,  32'h60, 32'h40, 0,      0,      32'h40, 1'b1, "glt_drop5");
    exp_at(t+11, 32'h60, 32'h40, 0,      0,      32'h40, 1'b1, "glt_hold6");
    exp_at(t+12, 32'h60, 0,      0,      32'h40, 32'h40, 1'b1, "glt_fall6");
    exp_at(t+14, 32'h60, 0,      0,      0,      32'h40, 1'b1, "glt_end");
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk_i); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if ({gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask, event_o & e.mask, irq_o} !==
            {e.gpio & e.mask, e.rise & e.mask, e.fall & e.mask, e.evt & e.mask, e.irq}) begin
          bad++;
          $display("FAIL %s cyc=%0d got g=%h r=%h f=%h e=%h irq=%b want g=%h r=%h f=%h e=%h irq=%b",
                   e.name, cyc, gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask,
                   event_o & e.mask, irq_o, e.gpio, e.rise, e.fall, e.evt, e.irq);
        end
      end
      if (k == 4) pad_gpio_i[5] = 1'b0;
      if (k == 5) pad_gpio_i[6] = 1'b0;
    end
  endtask

  task automatic test_clear_race();
    int t;
    apply_reset();
    t = cyc;
    pad_gpio_i[3] = 1'b1;
    exp_at(t+3, 32'h8, 32'h8, 32'h8, 0,     32'h8, 1'b1, "clr_rise");
    exp_at(t+6, 32'h8, 0,     0,     32'h8, 32'h8, 1'b1, "clr_fall");
    exp_at(t+7, 32'h8, 0,     0,     0,     32'h8, 1'b1, "clr_race_set_wins");
    exp_at(t+8, 32'h8, 0,     0,     0,     0,     1'b0, "clr_alone");
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_i); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if ({gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask, event_o & e.mask, irq_o} !==
            {e.gpio & e.mask, e.rise & e.mask, e.fall & e.mask, e.evt & e.mask, e.irq}) begin
          bad++;
          $display("FAIL %s cyc=%0d got g=%h r=%h f=%h e=%h irq=%b want g=%h r=%h f=%h e=%h irq=%b",
                   e.name, cyc, gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask,
                   event_o & e.mask, irq_o, e.gpio, e.rise, e.fall, e.evt, e.irq);
        end
      end
      if (k == 3) pad_gpio_i[3] = 1'b0;
      if (k == 6) event_clr_i[3] = 1'b1;
      if (k == 8) event_clr_i[3] = 1'b0;
    end
  endtask

  task automatic test_limit_change();
    int t;
    apply_reset();
    t = cyc;
    debounce_en_i = 32'h2; debounce_limit_i = 8'd200; pad_gpio_i[1] = 1'b1;
    exp_at(t+8,  32'h2, 0,     0,     0, 0,     1'b0, "lim_counting");
    exp_at(t+12, 32'h2, 0,     0,     0, 0,     1'b0, "lim_cnt10");
    exp_at(t+13, 32'h2, 32'h2, 32'h2, 0, 32'h2, 1'b1, "lim_lowered");
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk_i); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if ({gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask, event_o & e.mask, irq_o} !==
            {e.gpio & e.mask, e.rise & e.mask, e.fall & e.mask, e.evt & e.mask, e.irq}) begin
          bad++;
          $display("FAIL %s cyc=%0d got g=%h r=%h f=%h e=%h irq=%b want g=%h r=%h f=%h e=%h irq=%b",
                   e.name, cyc, gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask,
                   event_o & e.mask, irq_o, e.gpio, e.rise, e.fall, e.evt, e.irq);
        end
      end
      if (k == 12) debounce_limit_i = 8'd5;
    end
  endtask

  task automatic test_reset_midcount();
    int t;
    apply_reset();
    t = cyc;
    pad_gpio_i = ALL;
    exp_at(t+3,  ALL, ALL, ALL, 0, ALL, 1'b1, "rst_all_set");
    exp_at(t+8,  ALL, ALL, 0,   0, ALL, 1'b1, "rst_counting");
    exp_at(t+9,  ALL, 0,   0,   0, 0,   1'b0, "rst_cleared");
    exp_at(t+10, ALL, 0,   0,   0, 0,   1'b0, "rst_no_pulse");
    exp_at(t+11, ALL, 0,   0,   0, 0,   1'b0, "rst_sync");
    exp_at(t+12, ALL, ALL, ALL, 0, ALL, 1'b1, "rst_rise");
    exp_at(t+13, ALL, ALL, 0,   0, ALL, 1'b1, "rst_one_pulse");
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk_i); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if ({gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask, event_o & e.mask, irq_o} !==
            {e.gpio & e.mask, e.rise & e.mask, e.fall & e.mask, e.evt & e.mask, e.irq}) begin
          bad++;
          $display("FAIL %s cyc=%0d got g=%h r=%h f=%h e=%h irq=%b want g=%h r=%h f=%h e=%h irq=%b",
                   e.name, cyc, gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask,
                   event_o & e.mask, irq_o, e.gpio, e.rise, e.fall, e.evt, e.irq);
        end
      end
      if (k == 3) begin
        debounce_en_i = 32'h4; debounce_limit_i = 8'd10; pad_gpio_i[2] = 1'b0;
      end
      if (k == 8) rst_i = 1'b1;
      if (k == 9) begin
        rst_i = 1'b0; debounce_limit_i = 8'd0; pad_gpio_i = ALL;
      end
    end
  endtask

  task automatic test_independence();
    int t;
    apply_reset();
    t = cyc;
    debounce_en_i = EN_MIX; debounce_limit_i = 8'd2; pad_gpio_i = ALL;
    exp_at(t+3,  ALL, ~EN_MIX, ~EN_MIX, 0,       ~EN_MIX, 1'b1, "ind_bypass_rise");
    exp_at(t+4,  ALL, ~EN_MIX, 0,       0,       ~EN_MIX, 1'b1, "ind_filter_wait");
    exp_at(t+5,  ALL, ALL,     EN_MIX,  0,       ALL,     1'b1, "ind_filter_rise");
    exp_at(t+6,  ALL, ALL,     0,       0,       ALL,     1'b1, "ind_high");
    exp_at(t+9,  ALL, EN_MIX,  0,       ~EN_MIX, ALL,     1'b1, "ind_bypass_fall");
    exp_at(t+10, ALL, EN_MIX,  0,       0,       ALL,     1'b1, "ind_filter_hold");
    exp_at(t+11, ALL, 0,       0,       EN_MIX,  ALL,     1'b1, "ind_filter_fall");
    exp_at(t+12, ALL, 0,       0,       0,       ALL,     1'b1, "ind_events_all");
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk_i); #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        if ({gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask, event_o & e.mask, irq_o} !==
            {e.gpio & e.mask, e.rise & e.mask, e.fall & e.mask, e.evt & e.mask, e.irq}) begin
          bad++;
          $display("FAIL %s cyc=%0d got g=%h r=%h f=%h e=%h irq=%b want g=%h r=%h f=%h e=%h irq=%b",
                   e.name, cyc, gpio_o & e.mask, rise_o & e.mask, fall_o & e.mask,
                   event_o & e.mask, irq_o, e.gpio, e.rise, e.fall, e.evt, e.irq);
        end
      end
      if (k == 6) pad_gpio_i = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got time=%0t want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; pad_gpio_i = '0; debounce_en_i = '0; debounce_limit_i = '0;
    event_clr_i = '0;
    test_reset();
    test_bypass();
    test_filter();
    test_glitch();
    test_clear_race();
    test_limit_change();
    test_reset_midcount();
    test_independence();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
